// File: rtl/mmio_stream_port.sv
// Memory-mapped byte stream port: an RX FIFO the CPU reads and pops, and a
// one-byte TX holding register that drains over a valid/ready handshake.
// Reads are combinational; every side effect lands on the closing edge.
module mmio_stream_port #(
    parameter logic [31:0] BASE_ADDR = 32'hFF20_0100,
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDwReadEnable,
    input  logic        iDwWriteEnable,
    input  logic [3:0]  iDwByteEnable,
    input  logic [31:0] iDwAddress,
    input  logic [31:0] iDwWriteData,
    output logic [31:0] oDwReadData,
    input  logic [7:0]  iRxData,
    input  logic        iRxValid,
    output logic        oRxReady,
    output logic [7:0]  oTxData,
    output logic        oTxValid,
    input  logic        iTxReady,
    output logic        oIrq
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    fifoMem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [AW:0]   count;
    logic [AW:0]   countNext;
    logic          overflow;
    logic          irqEnable;
    logic          ieNext;
    logic [7:0]    txData;
    logic          txValid;
    logic          irq;

    logic       sel;
    logic [1:0] regIdx;
    logic       full;
    logic       nonEmpty;
    logic       wrLane0;
    logic       ctrlWr;
    logic       flush;
    logic       ovClear;
    logic       ovSet;
    logic       push;
    logic       pop;
    logic       txLoad;
    logic       unusedBits;

    assign sel      = (iDwAddress[31:4] == BASE_ADDR[31:4]);
    assign regIdx   = iDwAddress[3:2];
    assign full     = (count == FULL_COUNT);
    assign nonEmpty = (count != '0);
    assign wrLane0  = sel & iDwWriteEnable & iDwByteEnable[0];
    assign ctrlWr   = wrLane0 & (regIdx == 2'd2);
    assign flush    = ctrlWr & iDwWriteData[0];
    assign ovClear  = ctrlWr & iDwWriteData[1];
    // A byte arriving at a full FIFO is lost even if a pop frees a slot this cycle.
    assign ovSet    = iRxValid & full;
    // Flush wins over a same-cycle push or pop.
    assign push     = iRxValid & ~full & ~flush;
    assign pop      = sel & iDwReadEnable & (regIdx == 2'd0) & iDwByteEnable[0] & nonEmpty & ~flush;
    // A write arriving while a byte is still pending is dropped, even on the handshake cycle.
    assign txLoad   = wrLane0 & (regIdx == 2'd3) & ~txValid;
    assign ieNext   = ctrlWr ? iDwWriteData[2] : irqEnable;

    assign oRxReady = ~full;
    assign oTxData  = txData;
    assign oTxValid = txValid;
    assign oIrq     = irq;

    assign unusedBits = ^{iDwAddress[1:0], iDwWriteData[31:8], iDwByteEnable[3:1]};

    // Next FIFO occupancy; used for both the count register and the registered IRQ.
    always_comb begin
        countNext = count;
        if (flush) begin
            countNext = '0;
        end else begin
            countNext = count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // Combinational register read mux; zero whenever the port is not being read.
    always_comb begin
        oDwReadData = 32'h0;
        if (sel && iDwReadEnable) begin
            case (regIdx)
                2'd0: if (nonEmpty) oDwReadData = {24'h0, fifoMem[rdPtr]};
                2'd1: oDwReadData = {16'h0, 8'(count), 4'h0, txValid, overflow, full, nonEmpty};
                2'd2: oDwReadData = {29'h0, irqEnable, 2'b00};
                default: oDwReadData = {24'h0, txData};
            endcase
        end
    end

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge iCLK) begin
        if (push) begin
            fifoMem[wrPtr] <= iRxData;
        end
    end

    // Control state: pointers, count, flags, IRQ and the TX holding register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            irqEnable <= 1'b0;
            irq       <= 1'b0;
            txData    <= 8'h00;
            txValid   <= 1'b0;
        end else begin
            if (flush) begin
                rdPtr <= '0;
                wrPtr <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + AW'(1);
                if (pop)  rdPtr <= rdPtr + AW'(1);
            end
            count <= countNext;

            // Set beats a same-cycle clear so no overflow event is ever lost.
            if (ovSet) begin
                overflow <= 1'b1;
            end else if (ovClear) begin
                overflow <= 1'b0;
            end

            irqEnable <= ieNext;
            irq       <= ieNext & (countNext != '0);

            if (txLoad) begin
                txData  <= iDwWriteData[7:0];
                txValid <= 1'b1;
            end else if (txValid && iTxReady) begin
                txValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_stream_port.sv
// Bench for mmio_stream_port: RX bytes are queued in a scoreboard when pushed
// and compared when the CPU pops them; status and TX state come from a small model.
module tb_mmio_stream_port;

    localparam logic [31:0] BASE = 32'hFF20_0100;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iDwReadEnable;
    logic        iDwWriteEnable;
    logic [3:0]  iDwByteEnable;
    logic [31:0] iDwAddress;
    logic [31:0] iDwWriteData;
    logic [31:0] oDwReadData;
    logic [7:0]  iRxData;
    logic        iRxValid;
    logic        oRxReady;
    logic [7:0]  oTxData;
    logic        oTxValid;
    logic        iTxReady;
    logic        oIrq;

    int checks = 0;
    int failures = 0;

    logic [7:0] sbQ[$];
    logic       mOvf;
    logic       mTxV;
    logic [7:0] mTxD;

    mmio_stream_port dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iDwReadEnable(iDwReadEnable),
        .iDwWriteEnable(iDwWriteEnable),
        .iDwByteEnable(iDwByteEnable),
        .iDwAddress(iDwAddress),
        .iDwWriteData(iDwWriteData),
        .oDwReadData(oDwReadData),
        .iRxData(iRxData),
        .iRxValid(iRxValid),
        .oRxReady(oRxReady),
        .oTxData(oTxData),
        .oTxValid(oTxValid),
        .iTxReady(iTxReady),
        .oIrq(oIrq)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expStatus();
        int n;
        n = sbQ.size();
        return {16'h0, 8'(n), 4'h0, mTxV, mOvf, 1'(n == 16), 1'(n != 0)};
    endfunction

    task automatic tick();
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic busIdle();
        iDwReadEnable  = 1'b0;
        iDwWriteEnable = 1'b0;
        iDwByteEnable  = 4'h0;
        iDwAddress     = 32'h0;
        iDwWriteData   = 32'h0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        iDwReadEnable = 1'b1;
        iDwAddress    = addr;
        iDwByteEnable = 4'hF;
        #1 checkVal(tag, oDwReadData, exp);
        tick();
        busIdle();
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        iDwWriteEnable = 1'b1;
        iDwAddress     = addr;
        iDwWriteData   = data;
        iDwByteEnable  = be;
        tick();
        busIdle();
    endtask

    task automatic checkStatus(input string tag);
        readCheck(tag, BASE + 32'h4, expStatus());
    endtask

    task automatic pushRx(input logic [7:0] b);
        iRxValid = 1'b1;
        iRxData  = b;
        if (sbQ.size() < 16) sbQ.push_back(b);
        else mOvf = 1'b1;
        tick();
        iRxValid = 1'b0;
    endtask

    task automatic popRx(input string tag);
        logic [31:0] exp;
        exp = (sbQ.size() != 0) ? {24'h0, sbQ[0]} : 32'h0;
        readCheck(tag, BASE, exp);
        if (sbQ.size() != 0) void'(sbQ.pop_front());
    endtask

    initial begin
        iRST = 1'b0;
        iRxValid = 1'b0;
        iRxData = 8'h0;
        iTxReady = 1'b0;
        mOvf = 1'b0;
        mTxV = 1'b0;
        mTxD = 8'h0;
        busIdle();
        @(negedge iCLK);
        @(negedge iCLK);
        checkVal("rst_rxready", 32'(oRxReady), 32'h1);
        checkVal("rst_txvalid", 32'(oTxValid), 32'h0);
        checkVal("rst_irq", 32'(oIrq), 32'h0);
        checkVal("rst_rdata", oDwReadData, 32'h0);
        iRST = 1'b1;
        tick();

        // Basic push / pop
        checkStatus("status_reset");
        pushRx(8'h41);
        pushRx(8'h42);
        pushRx(8'h43);
        checkVal("status_3", expStatus(), 32'h0000_0301);
        checkStatus("status_3_dut");
        for (int i = 0; i < 3; i++) popRx("pop_abc");
        checkStatus("status_empty");

        // Fill to full across the pointer wrap, then overflow
        for (int i = 0; i < 16; i++) pushRx(8'(i));
        checkVal("full_rxready", 32'(oRxReady), 32'h0);
        checkStatus("status_full");
        pushRx(8'h99);
        checkStatus("status_ovf");
        for (int i = 0; i < 16; i++) popRx("drain_wrap");
        writeReg(BASE + 32'h8, 32'h2, 4'h1);
        mOvf = 1'b0;
        checkStatus("ovf_clear1");

        // Pop from full with a same-cycle arrival: arrival is dropped
        for (int i = 0; i < 16; i++) pushRx(8'h20 + 8'(i));
        iDwReadEnable = 1'b1;
        iDwAddress    = BASE;
        iDwByteEnable = 4'hF;
        iRxValid      = 1'b1;
        iRxData       = 8'h55;
        #1 checkVal("popfull_data", oDwReadData, {24'h0, sbQ[0]});
        checkVal("popfull_ready", 32'(oRxReady), 32'h0);
        tick();
        busIdle();
        iRxValid = 1'b0;
        void'(sbQ.pop_front());
        mOvf = 1'b1;
        checkStatus("popfull_status");
        writeReg(BASE + 32'h8, 32'h2, 4'h1);
        mOvf = 1'b0;
        checkStatus("ovf_clear2");

        // Simultaneous push and pop at count 5
        for (int i = 0; i < 10; i++) popRx("drain_to5");
        iDwReadEnable = 1'b1;
        iDwAddress    = BASE;
        iDwByteEnable = 4'hF;
        iRxValid      = 1'b1;
        iRxData       = 8'h77;
        #1 checkVal("pushpop_data", oDwReadData, {24'h0, sbQ[0]});
        tick();
        busIdle();
        iRxValid = 1'b0;
        void'(sbQ.pop_front());
        sbQ.push_back(8'h77);
        checkStatus("pushpop_status");

        // Flush beats a same-cycle push
        iDwWriteEnable = 1'b1;
        iDwAddress     = BASE + 32'h8;
        iDwWriteData   = 32'h1;
        iDwByteEnable  = 4'h1;
        iRxValid       = 1'b1;
        iRxData        = 8'h88;
        tick();
        busIdle();
        iRxValid = 1'b0;
        sbQ.delete();
        checkStatus("flush_status");
        popRx("empty_read");
        checkStatus("empty_read_status");

        // TX holding register
        writeReg(BASE + 32'hC, 32'h0000_005A, 4'hE);
        checkVal("tx_lane_ign", 32'(oTxValid), 32'h0);
        writeReg(BASE + 32'hC, 32'h0000_005A, 4'h1);
        mTxV = 1'b1;
        mTxD = 8'h5A;
        checkVal("tx_valid", 32'(oTxValid), 32'h1);
        checkVal("tx_data", 32'(oTxData), 32'h5A);
        readCheck("tx_read", BASE + 32'hC, {24'h0, mTxD});
        checkStatus("tx_busy_status");
        writeReg(BASE + 32'hC, 32'h0000_0033, 4'h1);
        checkVal("tx_busy_ign", 32'(oTxData), 32'h5A);
        iTxReady       = 1'b1;
        iDwWriteEnable = 1'b1;
        iDwAddress     = BASE + 32'hC;
        iDwWriteData   = 32'h44;
        iDwByteEnable  = 4'h1;
        tick();
        busIdle();
        iTxReady = 1'b0;
        mTxV = 1'b0;
        checkVal("tx_done_valid", 32'(oTxValid), 32'h0);
        checkVal("tx_done_data", 32'(oTxData), 32'h5A);
        writeReg(BASE + 32'hC, 32'h0000_0033, 4'h1);
        mTxV = 1'b1;
        mTxD = 8'h33;
        checkVal("tx_reload_valid", 32'(oTxValid), 32'h1);
        checkVal("tx_reload_data", 32'(oTxData), 32'h33);

        // Interrupt enable
        writeReg(BASE + 32'h8, 32'h4, 4'h1);
        readCheck("ctrl_read", BASE + 32'h8, 32'h4);
        checkVal("irq_idle", 32'(oIrq), 32'h0);
        pushRx(8'h61);
        checkVal("irq_set", 32'(oIrq), 32'h1);
        popRx("irq_pop");
        checkVal("irq_clr", 32'(oIrq), 32'h0);

        // Out-of-window accesses have no effect
        pushRx(8'h62);
        writeReg(BASE + 32'h18, 32'h1, 4'hF);
        readCheck("unsel_read", BASE + 32'h10, 32'h0);
        checkStatus("unsel_status");
        checkVal("unsel_irq", 32'(oIrq), 32'h1);

        // Asynchronous reset while a TX byte is pending
        #2 iRST = 1'b0;
        #1 checkVal("arst_txvalid", 32'(oTxValid), 32'h0);
        checkVal("arst_txdata", 32'(oTxData), 32'h0);
        checkVal("arst_irq", 32'(oIrq), 32'h0);
        checkVal("arst_rxready", 32'(oRxReady), 32'h1);
        @(negedge iCLK);
        sbQ.delete();
        mTxV = 1'b0;
        mOvf = 1'b0;
        checkStatus("arst_status");
        iRST = 1'b1;
        tick();
        readCheck("arst_ctrl", BASE + 32'h8, 32'h0);
        pushRx(8'hA5);
        checkVal("post_rst_irq", 32'(oIrq), 32'h0);
        popRx("post_rst_pop");
        checkStatus("post_rst_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_stream_port.md
Name: mmio_stream_port

Overview:
- Memory-mapped responder on the processor data bus: the target end of the DwReadEnable/DwWriteEnable/DwByteEnable/DwAddress/DwWriteData/DwReadData initiator interface.
- Receive path: byte stream, e.g. keyboard or serial, buffered in a FIFO that the CPU reads and pops.
- Transmit path: one-byte holding register that the CPU writes and that drains over a valid/ready handshake.
- Read data is combinational, so the single-cycle datapath samples it in the access cycle. All side effects (pop, push, clear, load) occur on the rising edge closing that cycle.

Parameters:
BASE_ADDR, 32'hFF20_0100, 16-byte-aligned base of the 4-word register window
DEPTH, 16, RX FIFO entries (power of two, >=2)
AW, 4, log2(DEPTH)

Ports:
iCLK  in  1  system clock, rising edge
iRST  in  1  reset, asynchronous, active-low (0 = reset)
iDwReadEnable  in  1  bus read strobe
iDwWriteEnable  in  1  bus write strobe
iDwByteEnable  in  4  byte lanes
iDwAddress  in  32  byte address
iDwWriteData  in  32  write data
oDwReadData  out  32  read data; 0 when not selected
iRxData  in  8  incoming byte
iRxValid  in  1  incoming byte valid
oRxReady  out  1  FIFO can accept (= !full)
oTxData  out  8  outgoing byte
oTxValid  out  1  outgoing byte valid
iTxReady  in  1  sink accepts byte
oIrq  out  1  interrupt request

Behaviour:
- Select: sel = (iDwAddress[31:4] == BASE_ADDR[31:4]). Register index = iDwAddress[3:2]. iDwAddress[1:0] is ignored.
- Register map (offset: name):
  - 0x0 RXDATA (R): {24'b0, head byte}; reads 0 when empty.
  - 0x4 STATUS (R): [15:8] count (zero-extended, AW+1 bits), [3] txbusy (=oTxValid), [2] overflow (sticky), [1] full, [0] nonempty. Other bits 0.
  - 0x8 CONTROL (R/W): [2] IE (read/write); [1] write-1 clears overflow; [0] write-1 flushes the FIFO. Bits [1:0] are self-clearing and read as 0.
  - 0xC TXDATA (W): byte lane 0 loads the TX holding register; reads return {24'b0, oTxData}.
- Read data: oDwReadData = register value when sel & iDwReadEnable, else 32'h0. Purely combinational; no read latency.
- Writes take effect at the edge only when sel & iDwWriteEnable & iDwByteEnable[0]. Other lanes are ignored. Writes to RXDATA/STATUS are ignored.
- Pop: at the edge when sel & iDwReadEnable & index==0 & iDwByteEnable[0] & nonempty. Read pointer increments mod DEPTH, count decrements. A read of RXDATA when empty has no effect.
- Push: at the edge when iRxValid & !full. Byte is written at the write pointer, pointer increments mod DEPTH, count increments.
- Overflow: iRxValid & full at an edge drops the byte and sets overflow. Overflow stays set until a CONTROL write of bit1 or reset.
- full = (count == DEPTH); nonempty = (count != 0). oRxReady is combinational from the registered count.
- Simultaneous push and pop (not full): both occur, count unchanged.
  - When full and popped in the same cycle, oRxReady is still 0: the push is not accepted and overflow is set if iRxValid.
- Flush (CONTROL bit0): pointers and count go to 0 at the edge. Flush beats a same-cycle push or pop; that push is dropped without setting overflow.
- Overflow clear and a same-cycle overflow event: the set wins.
- TX path: a TXDATA write when oTxValid==0 loads oTxData and sets oTxValid at the edge.
  - A TXDATA write when oTxValid==1 is ignored, including the cycle in which the handshake completes.
  - oTxValid clears at the edge where oTxValid & iTxReady.
  - oTxData is held stable while oTxValid is set.
- oIrq = IE & nonempty, registered: it reflects state after the edge.
- Reset (iRST=0, asynchronous): pointers=0, count=0, overflow=0, IE=0, oTxValid=0, oTxData=8'h00, oIrq=0. Consequently oRxReady=1 and oDwReadData=0 unless selected.
  - Reset mid-transfer discards FIFO contents and any pending TX byte.
- Width rules: count is AW+1 bits; pointers are AW bits and wrap naturally.

Test Plan:
- Reset then STATUS read at 0xFF200104 -> 32'h0. Push 0x41,0x42,0x43 via iRxValid -> STATUS=32'h00000301. Three RXDATA reads return 0x41, 0x42, 0x43 -> STATUS=0.
- Push 16 bytes 0x00..0x0F -> oRxReady=0, STATUS=32'h00001003. Push 0x99 -> dropped, STATUS bit2=1. Drain -> 0x00..0x0F in order with pointer wrap.
- FIFO full, same-cycle RXDATA pop and iRxValid=0x55 -> count 15, 0x55 dropped, overflow=1. Then write CONTROL=32'h2 -> overflow=0.
- Count 5, simultaneous pop and push 0x77 -> count stays 5. Write CONTROL=32'h1 in the same cycle as a push -> count 0, overflow 0.
- Write TXDATA=32'h0000005A with iTxReady=0 -> oTxValid=1, oTxData=0x5A. Write 0x33 -> ignored. iTxReady=1 for one cycle -> oTxValid=0. Write 0x33 -> accepted.
- Write CONTROL=32'h4, push one byte -> oIrq=1 after the edge; pop -> oIrq=0. Access to 0xFF200110 -> oDwReadData=0, no state change. Assert iRST=0 mid-TX -> oTxValid=0 immediately.
